// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================
// mem_responder_pkg : FSM state type and default parameters
// Rev 1.0
// ============================================================
package mem_responder_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 1024;
  localparam int DEF_LATENCY    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_responder_ram.sv
`default_nettype none
// ============================================================
// mem_responder_ram : single-port RAM, sync write, registered read
// Rev 1.0
// ============================================================
module mem_responder_ram
  import mem_responder_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int AW         = $clog2(DEF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================
// mem_responder : fixed-latency memory responder with range check
// Rev 1.0
// ============================================================
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mem_valid_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_adr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  output logic                  mem_ready_o,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  mem_err_o,
  output logic                  busy_o
);

  localparam int                  RAM_AW    = $clog2(DEPTH);
  localparam int                  CNT_W     = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic                    valid_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    accept;
  logic                    enter_resp;
  logic                    in_range;
  logic                    ram_we;
  logic [RAM_AW-1:0]       ram_adr;
  logic [DATA_WIDTH-1:0]   ram_rdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    enter_resp = 1'b0;
    busy_o     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_valid_i && !valid_q) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        busy_o = 1'b1;
        if (cnt == CNT_LAST) begin
          enter_resp = 1'b1;
          state_nxt  = RESP;
        end
      end
      RESP: begin
        busy_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_range = ({1'b0, adr_q} < DEPTH_EXT);
  assign ram_we   = enter_resp & we_q & in_range;
  // The RAM read port follows the request from the accept edge onward so
  // its registered output is already valid by the edge entering RESP.
  assign ram_adr  = accept ? mem_adr_i[RAM_AW-1:0] : adr_q[RAM_AW-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q     <= 1'b0;
      cnt         <= '0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      wdata_q     <= '0;
      mem_ready_o <= 1'b0;
      mem_err_o   <= 1'b0;
      mem_rdata_o <= '0;
    end else begin
      valid_q     <= mem_valid_i;
      mem_ready_o <= enter_resp;
      mem_err_o   <= enter_resp & ~in_range;
      if (accept) begin
        we_q    <= mem_we_i;
        adr_q   <= mem_adr_i;
        wdata_q <= mem_wdata_i;
        cnt     <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (enter_resp && !we_q) begin
        mem_rdata_o <= in_range ? ram_rdata : '0;
      end
    end
  end

  mem_responder_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (RAM_AW)
  ) u_ram (
    .clk   (clk_i),
    .we    (ram_we),
    .addr  (ram_adr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================
// tb_mem_responder : self-checking bench for mem_responder
// Rev 1.0
// ============================================================
module tb_mem_responder;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int DEP = 1024;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          mem_valid_i;
  logic          mem_we_i;
  logic [AW-1:0] mem_adr_i;
  logic [DW-1:0] mem_wdata_i;
  logic          mem_ready_o;
  logic [DW-1:0] mem_rdata_o;
  logic          mem_err_o;
  logic          busy_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [int];
  int          wq [$];
  logic [31:0] last_rd = '0;

  typedef struct {
    bit          we;
    logic [15:0] adr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [10];

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEP),
    .LATENCY    (LAT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .mem_valid_i (mem_valid_i),
    .mem_we_i    (mem_we_i),
    .mem_adr_i   (mem_adr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_ready_o (mem_ready_o),
    .mem_rdata_o (mem_rdata_o),
    .mem_err_o   (mem_err_o),
    .busy_o      (busy_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request from IDLE with valid low at the previous edge;
  // the expected pulse falls in the LAT-th cycle after the accept edge.
  task automatic run_txn(input bit we, input logic [15:0] adr, input logic [31:0] wdata,
                         input bit exp_err, input logic [31:0] exp_rd,
                         input bit scramble, input string tag);
    logic [31:0] want_rd;
    want_rd     = we ? last_rd : exp_rd;
    mem_valid_i = 1'b1;
    mem_we_i    = we;
    mem_adr_i   = adr;
    mem_wdata_i = wdata;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      chk({tag, ".busy"}, {31'b0, busy_o}, 32'd1);
      chk({tag, ".ready"}, {31'b0, mem_ready_o}, {31'b0, (k == LAT)});
      if (k == LAT) begin
        chk({tag, ".err"}, {31'b0, mem_err_o}, {31'b0, exp_err});
        chk({tag, ".rdata"}, mem_rdata_o, want_rd);
      end
      mem_valid_i = 1'b0;
      if (scramble) begin
        mem_adr_i   = 16'($urandom);
        mem_wdata_i = $urandom;
      end
    end
    @(negedge clk);
    chk({tag, ".ready_after"}, {31'b0, mem_ready_o}, 32'd0);
    chk({tag, ".busy_after"}, {31'b0, busy_o}, 32'd0);
    chk({tag, ".rdata_held"}, mem_rdata_o, want_rd);
    last_rd = want_rd;
    if (we && !exp_err) begin
      model[int'(adr)] = wdata;
      wq.push_back(int'(adr));
    end
  endtask

  initial begin
    int          pulses;
    int          pos;
    bit          r_we;
    logic [15:0] r_adr;
    logic [31:0] r_wd;
    bit          r_err;
    logic [31:0] r_exp;

    tbl[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 16'h0010, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 16'h0000, 32'h0BADF00D, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 16'h0400, 32'h12345678, 1'b1, 32'h0};
    tbl[4] = '{1'b0, 16'h0400, 32'h0,        1'b1, 32'h0};
    tbl[5] = '{1'b0, 16'h0000, 32'h0,        1'b0, 32'h0BADF00D};
    tbl[6] = '{1'b1, 16'h03FF, 32'h55AA55AA, 1'b0, 32'h0};
    tbl[7] = '{1'b0, 16'h03FF, 32'h0,        1'b0, 32'h55AA55AA};
    tbl[8] = '{1'b1, 16'hFFFF, 32'h87654321, 1'b1, 32'h0};
    tbl[9] = '{1'b0, 16'h03FF, 32'h0,        1'b0, 32'h55AA55AA};

    rst_i       = 1'b1;
    mem_valid_i = 1'b0;
    mem_we_i    = 1'b0;
    mem_adr_i   = '0;
    mem_wdata_i = '0;
    repeat (3) @(negedge clk);
    chk("rst.ready", {31'b0, mem_ready_o}, 32'd0);
    chk("rst.busy",  {31'b0, busy_o},      32'd0);
    chk("rst.err",   {31'b0, mem_err_o},   32'd0);
    chk("rst.rdata", mem_rdata_o,          32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i].we, tbl[i].adr, tbl[i].wdata, tbl[i].exp_err, tbl[i].exp_rd,
              1'b0, $sformatf("tbl%0d", i));
    end

    // Valid held high across a whole transaction yields a single pulse.
    run_txn(1'b1, 16'h0020, 32'h20202020, 1'b0, 32'h0, 1'b0, "hold.pre");
    mem_valid_i = 1'b1;
    mem_we_i    = 1'b0;
    mem_adr_i   = 16'h0020;
    pulses = 0;
    pos    = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_ready_o === 1'b1) begin
        pulses++;
        if (pos < 0) pos = c;
      end
    end
    chk("hold.pulses", 32'(pulses), 32'd1);
    chk("hold.pos", 32'(pos), 32'(LAT));
    chk("hold.rdata", mem_rdata_o, 32'h20202020);
    mem_valid_i = 1'b0;
    @(negedge clk);
    mem_valid_i = 1'b1;
    pulses = 0;
    pos    = -1;
    for (int c = 0; c <= LAT + 2; c++) begin
      @(negedge clk);
      if (mem_ready_o === 1'b1) begin
        pulses++;
        if (pos < 0) pos = c;
      end
    end
    chk("rearm.pulses", 32'(pulses), 32'd1);
    chk("rearm.pos", 32'(pos), 32'(LAT));
    mem_valid_i = 1'b0;
    @(negedge clk);
    last_rd = 32'h20202020;

    // Reset in the middle of a write must drop it.
    run_txn(1'b1, 16'h0030, 32'h11111111, 1'b0, 32'h0, 1'b0, "rstmid.pre");
    mem_valid_i = 1'b1;
    mem_we_i    = 1'b1;
    mem_adr_i   = 16'h0030;
    mem_wdata_i = 32'hCAFEF00D;
    @(negedge clk);
    mem_valid_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk("rstmid.busy_async", {31'b0, busy_o}, 32'd0);
    @(negedge clk);
    chk("rstmid.ready", {31'b0, mem_ready_o}, 32'd0);
    chk("rstmid.busy",  {31'b0, busy_o},      32'd0);
    chk("rstmid.err",   {31'b0, mem_err_o},   32'd0);
    chk("rstmid.rdata", mem_rdata_o,          32'd0);
    rst_i  = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_ready_o === 1'b1) pulses++;
    end
    chk("rstmid.no_pulse", 32'(pulses), 32'd0);
    last_rd = '0;
    run_txn(1'b0, 16'h0030, 32'h0, 1'b0, 32'h11111111, 1'b0, "rstmid.read");

    // Inputs wander during WAIT; the captured request must win.
    run_txn(1'b1, 16'h0040, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b1, "scramble.wr");
    run_txn(1'b0, 16'h0040, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b0, "scramble.rd");

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r_we = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) begin
        r_adr = 16'(DEP + $urandom_range(0, 65535 - DEP));
      end else if (r_we) begin
        r_adr = 16'($urandom_range(0, DEP - 1));
      end else begin
        r_adr = 16'(wq[$urandom_range(0, wq.size() - 1)]);
      end
      r_wd  = $urandom;
      r_err = (int'(r_adr) >= DEP);
      r_exp = (r_we || r_err) ? 32'h0 : model[int'(r_adr)];
      run_txn(r_we, r_adr, r_wd, r_err, r_exp, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
